// File: rtl/quad_encoder_tracker_pkg.sv
// Shared definitions for the quadrature encoder tracker: Gray phase constants,
// channel FSM states and the forward/reverse phase successor helpers.
package quad_encoder_tracker_pkg;

   localparam logic [1:0] PH_00 = 2'b00;
   localparam logic [1:0] PH_01 = 2'b01;
   localparam logic [1:0] PH_11 = 2'b11;
   localparam logic [1:0] PH_10 = 2'b10;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_TRACK = 1'b1
   } state_e;

   // Forward sequence is 00 -> 01 -> 11 -> 10 -> 00.
   function automatic logic [1:0] phase_next(input logic [1:0] ph);
      case (ph)
         PH_00:   return PH_01;
         PH_01:   return PH_11;
         PH_11:   return PH_10;
         default: return PH_00;
      endcase
   endfunction

   function automatic logic [1:0] phase_prev(input logic [1:0] ph);
      case (ph)
         PH_00:   return PH_10;
         PH_10:   return PH_11;
         PH_11:   return PH_01;
         default: return PH_00;
      endcase
   endfunction

endpackage

// File: rtl/quad_channel.sv
// One encoder channel: 2-flop pin synchroniser, debounce filter, phase-tracking FSM
// and the up/down position counter with direction, step and sticky error flags.
module quad_channel
   import quad_encoder_tracker_pkg::*;
#(
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned DEB_CYC  = 4,
   parameter int unsigned SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   input  logic             b,
   input  logic             clear,
   output logic [CNT_W-1:0] count,
   output logic             dir,
   output logic             step,
   output logic             err
);

   localparam int unsigned      DebW   = $clog2(DEB_CYC + 1);
   localparam logic [DebW-1:0]  DebMax = DebW'(DEB_CYC);
   localparam logic [DebW-1:0]  DebOne = DebW'(1);
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [1:0]       sync1_q, sync2_q;
   logic [1:0]       cand_q, cand_d;
   logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
   logic             done_q, done_d;
   logic             accept;
   state_e           st_q, st_d;
   logic [1:0]       prev_q, prev_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             dir_q, dir_d;
   logic             step_q, step_d;
   logic             err_q, err_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= PH_00;
         sync2_q   <= PH_00;
         cand_q    <= PH_00;
         deb_cnt_q <= '0;
         done_q    <= 1'b0;
         st_q      <= ST_INIT;
         prev_q    <= PH_00;
         count_q   <= '0;
         dir_q     <= 1'b0;
         step_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         sync1_q   <= {b, a};
         sync2_q   <= sync1_q;
         cand_q    <= cand_d;
         deb_cnt_q <= deb_cnt_d;
         done_q    <= done_d;
         st_q      <= st_d;
         prev_q    <= prev_d;
         count_q   <= count_d;
         dir_q     <= dir_d;
         step_q    <= step_d;
         err_q     <= err_d;
      end
   end

   // A candidate is accepted exactly once, on the cycle its stability count hits DEB_CYC.
   always_comb begin
      cand_d    = cand_q;
      deb_cnt_d = deb_cnt_q;
      done_d    = done_q;
      accept    = (deb_cnt_q == DebMax) && !done_q;
      if (sync2_q != cand_q) begin
         cand_d    = sync2_q;
         deb_cnt_d = '0;
         done_d    = 1'b0;
      end else begin
         if (deb_cnt_q != DebMax) deb_cnt_d = deb_cnt_q + DebOne;
         if (accept) done_d = 1'b1;
      end
   end

   always_comb begin
      st_d    = st_q;
      prev_d  = prev_q;
      count_d = count_q;
      dir_d   = dir_q;
      step_d  = 1'b0;
      err_d   = err_q;
      if (accept) begin
         prev_d = cand_q;
         case (st_q)
            ST_INIT: st_d = ST_TRACK;
            default: begin
               if (cand_q == phase_next(prev_q)) begin
                  step_d = 1'b1;
                  dir_d  = 1'b1;
                  if (!(SATURATE != 0 && count_q == CntMax)) count_d = count_q + CntOne;
               end else if (cand_q == phase_prev(prev_q)) begin
                  step_d = 1'b1;
                  dir_d  = 1'b0;
                  if (!(SATURATE != 0 && count_q == '0)) count_d = count_q - CntOne;
               end else if (cand_q != prev_q) begin
                  err_d = 1'b1;
               end
            end
         endcase
      end
      // Clear overrides the counter and error only; a coincident step still pulses.
      if (clear) begin
         count_d = '0;
         err_d   = 1'b0;
      end
   end

   assign count = count_q;
   assign dir   = dir_q;
   assign step  = step_q;
   assign err   = err_q;

endmodule

// File: rtl/quad_encoder_tracker.sv
// Multi-channel quadrature encoder tracker: NUM_CH independent channels with packed
// position outputs, channel i occupying count[i*CNT_W +: CNT_W].
module quad_encoder_tracker
   import quad_encoder_tracker_pkg::*;
#(
   parameter int unsigned NUM_CH   = 2,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned DEB_CYC  = 4,
   parameter int unsigned SATURATE = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       quad_a,
   input  logic [NUM_CH-1:0]       quad_b,
   input  logic [NUM_CH-1:0]       clear,
   output logic [NUM_CH*CNT_W-1:0] count,
   output logic [NUM_CH-1:0]       dir,
   output logic [NUM_CH-1:0]       step,
   output logic [NUM_CH-1:0]       err
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      quad_channel #(
         .CNT_W    (CNT_W),
         .DEB_CYC  (DEB_CYC),
         .SATURATE (SATURATE)
      ) u_ch (
         .clk   (clk),
         .rst   (rst),
         .a     (quad_a[i]),
         .b     (quad_b[i]),
         .clear (clear[i]),
         .count (count[i*CNT_W +: CNT_W]),
         .dir   (dir[i]),
         .step  (step[i]),
         .err   (err[i])
      );
   end

endmodule

// File: tb/tb_quad_encoder_tracker.sv
// Bench for quad_encoder_tracker: directed scenarios plus random pin activity, all
// outputs compared every cycle against a run-length/Gray-position reference model.
module tb_quad_encoder_tracker;

   localparam int unsigned NUM_CH   = 2;
   localparam int unsigned CNT_W    = 16;
   localparam int unsigned DEB_CYC  = 4;
   localparam int unsigned SATURATE = 0;
   localparam int unsigned MODV     = 1 << CNT_W;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [NUM_CH-1:0]       quad_a = '0;
   logic [NUM_CH-1:0]       quad_b = '0;
   logic [NUM_CH-1:0]       clear = '0;
   logic [NUM_CH*CNT_W-1:0] count;
   logic [NUM_CH-1:0]       dir;
   logic [NUM_CH-1:0]       step;
   logic [NUM_CH-1:0]       err;

   quad_encoder_tracker #(
      .NUM_CH   (NUM_CH),
      .CNT_W    (CNT_W),
      .DEB_CYC  (DEB_CYC),
      .SATURATE (SATURATE)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .quad_a (quad_a),
      .quad_b (quad_b),
      .clear  (clear),
      .count  (count),
      .dir    (dir),
      .step   (step),
      .err    (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int unsigned dut_cnt(input int ch);
      return 32'(count[ch*CNT_W +: CNT_W]);
   endfunction

   // Position of a phase along the forward Gray cycle 00,01,11,10.
   function automatic int gpos(input logic [1:0] p);
      case (p)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   // Reference model: a pin phase seen for DEB_CYC+1 consecutive edges is accepted and
   // takes effect 3 edges after its last required sample.
   typedef struct {
      int         due;
      int         ch;
      logic [1:0] ph;
   } ev_t;

   ev_t         evq[$];
   int          cyc = 0;
   int unsigned m_cnt[NUM_CH];
   bit          m_dir[NUM_CH];
   bit          m_step[NUM_CH];
   bit          m_err[NUM_CH];
   bit          m_trk[NUM_CH];
   logic [1:0]  m_prev[NUM_CH];
   logic [1:0]  run_ph[NUM_CH];
   int          run_len[NUM_CH];

   always @(posedge clk) begin
      ev_t ev;
      int  d;
      logic [1:0] x;
      cyc++;
      for (int c = 0; c < NUM_CH; c++) m_step[c] = 1'b0;
      if (rst) begin
         evq.delete();
         for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = 0; m_dir[c] = 0; m_err[c] = 0; m_trk[c] = 0; m_prev[c] = 2'b00;
            // Cleared synchroniser/debounce state behaves like three prior 00 samples.
            run_ph[c] = 2'b00; run_len[c] = 3;
         end
      end else begin
         while (evq.size() > 0 && evq[0].due == cyc) begin
            ev = evq.pop_front();
            if (!m_trk[ev.ch]) begin
               m_trk[ev.ch] = 1'b1;
            end else begin
               d = (gpos(ev.ph) - gpos(m_prev[ev.ch]) + 4) % 4;
               if (d == 1) begin
                  m_step[ev.ch] = 1; m_dir[ev.ch] = 1;
                  if (SATURATE != 0) begin
                     if (m_cnt[ev.ch] < MODV - 1) m_cnt[ev.ch]++;
                  end else m_cnt[ev.ch] = (m_cnt[ev.ch] + 1) % MODV;
               end else if (d == 3) begin
                  m_step[ev.ch] = 1; m_dir[ev.ch] = 0;
                  if (SATURATE != 0) begin
                     if (m_cnt[ev.ch] > 0) m_cnt[ev.ch]--;
                  end else m_cnt[ev.ch] = (m_cnt[ev.ch] + MODV - 1) % MODV;
               end else if (d == 2) begin
                  m_err[ev.ch] = 1;
               end
            end
            m_prev[ev.ch] = ev.ph;
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if (clear[c]) begin m_cnt[c] = 0; m_err[c] = 0; end
            x = {quad_b[c], quad_a[c]};
            if (x == run_ph[c]) run_len[c]++;
            else begin run_ph[c] = x; run_len[c] = 1; end
            if (run_len[c] == DEB_CYC + 1) evq.push_back('{due: cyc + 3, ch: c, ph: x});
         end
      end
   end

   bit chk_en = 1'b0;
   int pulses[NUM_CH];

   initial for (int c = 0; c < NUM_CH; c++) pulses[c] = 0;

   always @(negedge clk) begin
      for (int c = 0; c < NUM_CH; c++) if (step[c]) pulses[c]++;
      if (chk_en) begin
         for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("model_count%0d@%0d", c, cyc), dut_cnt(c), m_cnt[c]);
            check($sformatf("model_dir%0d@%0d", c, cyc), 32'(dir[c]), 32'(m_dir[c]));
            check($sformatf("model_step%0d@%0d", c, cyc), 32'(step[c]), 32'(m_step[c]));
            check($sformatf("model_err%0d@%0d", c, cyc), 32'(err[c]), 32'(m_err[c]));
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_ph(input int ch, input logic [1:0] ph);
      quad_a[ch] = ph[0];
      quad_b[ch] = ph[1];
   endtask

   initial begin
      int t0, lat, base0, base1, hold[NUM_CH];
      bit got;
      logic [1:0] cur[NUM_CH];
      logic [1:0] seq_f[3];
      logic [1:0] seq_r[4];

      // Reset state
      wait_cyc(3);
      rst = 1'b0;
      chk_en = 1'b1;
      check("rst_count0", dut_cnt(0), 0);
      check("rst_count1", dut_cnt(1), 0);
      check("rst_flags", 32'({dir, step, err}), 0);

      // 1: forward sequence with first-step latency
      wait_cyc(20);
      base0 = pulses[0];
      set_ph(0, 2'b01);
      t0 = cyc + 1;
      got = 0; lat = -1;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (step[0]) begin got = 1; lat = cyc - t0; end
      end
      check("t1_latency", 32'(lat), 7);
      wait_cyc(13);
      seq_f = '{2'b11, 2'b10, 2'b00};
      for (int i = 0; i < 3; i++) begin set_ph(0, seq_f[i]); wait_cyc(20); end
      check("t1_count", dut_cnt(0), 4);
      check("t1_dir", 32'(dir[0]), 1);
      check("t1_err", 32'(err[0]), 0);
      check("t1_pulses", 32'(pulses[0] - base0), 4);

      // 2: reverse back to zero, then wrap below zero
      seq_r = '{2'b10, 2'b11, 2'b01, 2'b00};
      for (int i = 0; i < 4; i++) begin set_ph(0, seq_r[i]); wait_cyc(20); end
      check("t2_count", dut_cnt(0), 0);
      check("t2_dir", 32'(dir[0]), 0);
      set_ph(0, 2'b10); wait_cyc(20);
      check("t2_wrap", dut_cnt(0), SATURATE != 0 ? 0 : MODV - 1);
      check("t2_pulses", 32'(pulses[0] - base0), 9);

      // 3: short glitch is filtered
      set_ph(0, 2'b00); wait_cyc(20);
      base0 = pulses[0];
      set_ph(0, 2'b01); wait_cyc(3);
      set_ph(0, 2'b00); wait_cyc(20);
      check("t3_pulses", 32'(pulses[0] - base0), 0);
      check("t3_count", dut_cnt(0), 0);

      // 4: illegal jump, recovery, clear
      set_ph(0, 2'b11); wait_cyc(20);
      check("t4_err", 32'(err[0]), 1);
      check("t4_pulses", 32'(pulses[0] - base0), 0);
      check("t4_count", dut_cnt(0), 0);
      set_ph(0, 2'b10); wait_cyc(20);
      check("t4_count_after", dut_cnt(0), 1);
      check("t4_dir_after", 32'(dir[0]), 1);
      clear[0] = 1'b1; @(negedge clk); clear[0] = 1'b0;
      check("t4_clr_count", dut_cnt(0), 0);
      check("t4_clr_err", 32'(err[0]), 0);

      // 5: clear coincident with an accepted forward step
      set_ph(0, 2'b00); wait_cyc(20);
      set_ph(0, 2'b01); wait_cyc(20);
      set_ph(0, 2'b00); wait_cyc(20);
      check("t5_pre_count", dut_cnt(0), 1);
      check("t5_pre_dir", 32'(dir[0]), 0);
      set_ph(0, 2'b01);
      t0 = cyc + 1;
      wait_cyc(7);
      clear[0] = 1'b1; @(negedge clk); clear[0] = 1'b0;
      check("t5_cyc", 32'(cyc - t0), 7);
      check("t5_count", dut_cnt(0), 0);
      check("t5_step", 32'(step[0]), 1);
      check("t5_dir", 32'(dir[0]), 1);

      // 6: two channels together, then reset mid-debounce
      set_ph(0, 2'b00); set_ph(1, 2'b00);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      wait_cyc(20);
      seq_f = '{2'b01, 2'b11, 2'b10};
      seq_r[0] = 2'b10; seq_r[1] = 2'b11;
      for (int i = 0; i < 3; i++) begin
         set_ph(0, seq_f[i]);
         if (i < 2) set_ph(1, seq_r[i]);
         wait_cyc(20);
      end
      check("t6_count0", dut_cnt(0), 3);
      check("t6_count1", dut_cnt(1), MODV - 2);
      set_ph(0, 2'b00);
      wait_cyc(3);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      check("t6_rst_count0", dut_cnt(0), 0);
      check("t6_rst_count1", dut_cnt(1), 0);
      check("t6_rst_flags", 32'({dir, step, err}), 0);
      base0 = pulses[0]; base1 = pulses[1];
      wait_cyc(20);
      check("t6_init_pulses", 32'(pulses[0] - base0 + pulses[1] - base1), 0);
      set_ph(0, 2'b01); wait_cyc(20);
      check("t6_after_count0", dut_cnt(0), 1);

      // Random activity on all channels
      for (int c = 0; c < NUM_CH; c++) begin
         cur[c] = {quad_b[c], quad_a[c]};
         hold[c] = 1;
      end
      for (int n = 0; n < 4000; n++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            hold[c]--;
            if (hold[c] <= 0) begin
               int r;
               r = int'($urandom_range(0, 99));
               if (r < 45) cur[c] = (gpos(cur[c]) == 0) ? 2'b01 : (gpos(cur[c]) == 1) ? 2'b11 :
                                    (gpos(cur[c]) == 2) ? 2'b10 : 2'b00;
               else if (r < 85) cur[c] = (gpos(cur[c]) == 0) ? 2'b10 :
                                         (gpos(cur[c]) == 1) ? 2'b00 :
                                         (gpos(cur[c]) == 2) ? 2'b01 : 2'b11;
               else if (r < 93) cur[c] = cur[c] ^ 2'b11;
               set_ph(c, cur[c]);
               hold[c] = int'($urandom_range(1, 14));
            end
            clear[c] = ($urandom_range(0, 79) == 0);
         end
         rst = ($urandom_range(0, 699) == 0);
         @(negedge clk);
      end
      clear = '0;
      rst = 1'b0;
      wait_cyc(20);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
